exu_wbu: RTL and testbench

Writeback unit for the execution stage: the consumer end of the ALU result interface (`result`/`reg_we`/`reg_waddr`). It merges the single-cycle ALU result stream and a multi-cycle MDU result stream onto the single register-file write port. MDU results are buffered in a small FIFO, the ALU has priority, and a starvation counter forces the FIFO to drain. It sits between the EXU functional units and the GPR file.

---
 rtl/exu_wbu.sv | 118 +++++++++++
 tb/tb_exu_wbu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_wbu.sv
// EXU writeback: merges ALU and buffered MDU results onto the GPR write port.
// ALU has priority; a starvation counter forces the MDU FIFO head through.
module exu_wbu #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_reg_we_i,
  input  logic [4:0]  alu_reg_waddr_i,
  input  logic [31:0] alu_result_i,
  input  logic        mdu_valid_i,
  output logic        mdu_ready_o,
  input  logic [4:0]  mdu_waddr_i,
  input  logic [31:0] mdu_result_i,
  input  logic        int_assert_i,
  output logic        alu_stall_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        mdu_wb_done_o,
  output logic [4:0]  mdu_wb_addr_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [4:0]    addr_mem [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [3:0]    starve_cnt;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          alu_req;
  logic          alu_win;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign mdu_ready_o = rst_n & ~full;
  assign push        = mdu_valid_i & mdu_ready_o;
  assign alu_req     = alu_reg_we_i & (alu_reg_waddr_i != 5'd0);

  assign head_addr = addr_mem[rd_ptr[AW-1:0]];
  assign head_data = data_mem[rd_ptr[AW-1:0]];

  // Priority order: interrupt, forced drain, ALU, FIFO head.
  always_comb begin
    pop     = 1'b0;
    alu_win = 1'b0;
    if (int_assert_i) begin
      pop     = 1'b0;
    end else if (alu_stall_o && !empty) begin
      pop     = 1'b1;
    end else if (alu_req) begin
      alu_win = 1'b1;
    end else if (!empty) begin
      pop     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr[AW-1:0]] <= mdu_waddr_i;
      data_mem[wr_ptr[AW-1:0]] <= mdu_result_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      starve_cnt    <= '0;
      alu_stall_o   <= 1'b0;
      reg_we_o      <= 1'b0;
      reg_waddr_o   <= '0;
      reg_wdata_o   <= '0;
      mdu_wb_done_o <= 1'b0;
      mdu_wb_addr_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      reg_we_o <= alu_win | (pop & (head_addr != 5'd0));
      if (alu_win) begin
        reg_waddr_o <= alu_reg_waddr_i;
        reg_wdata_o <= alu_result_i;
      end else if (pop && head_addr != 5'd0) begin
        reg_waddr_o <= head_addr;
        reg_wdata_o <= head_data;
      end

      mdu_wb_done_o <= pop;
      if (pop) mdu_wb_addr_o <= head_addr;

      alu_stall_o <= 1'b0;
      if (int_assert_i) begin
        starve_cnt <= starve_cnt;
      end else if (pop || empty) begin
        starve_cnt <= '0;
      end else if (alu_win) begin
        if (starve_cnt + 4'd1 == 4'(STARVE_LIMIT)) begin
          starve_cnt  <= '0;
          alu_stall_o <= 1'b1;
        end else if (starve_cnt != 4'hF) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exu_wbu.sv
// Directed bench for exu_wbu: ALU path, MDU FIFO fill/drain,
// starvation, interrupt, x0 retire with wrap, and mid-run reset.
module tb_exu_wbu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_reg_we_i;
  logic [4:0]  alu_reg_waddr_i;
  logic [31:0] alu_result_i;
  logic        mdu_valid_i;
  logic        mdu_ready_o;
  logic [4:0]  mdu_waddr_i;
  logic [31:0] mdu_result_i;
  logic        int_assert_i;
  logic        alu_stall_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        mdu_wb_done_o;
  logic [4:0]  mdu_wb_addr_o;

  int tests = 0;
  int fails = 0;

  exu_wbu #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_reg_we_i    (alu_reg_we_i),
    .alu_reg_waddr_i (alu_reg_waddr_i),
    .alu_result_i    (alu_result_i),
    .mdu_valid_i     (mdu_valid_i),
    .mdu_ready_o     (mdu_ready_o),
    .mdu_waddr_i     (mdu_waddr_i),
    .mdu_result_i    (mdu_result_i),
    .int_assert_i    (int_assert_i),
    .alu_stall_o     (alu_stall_o),
    .reg_we_o        (reg_we_o),
    .reg_waddr_o     (reg_waddr_o),
    .reg_wdata_o     (reg_wdata_o),
    .mdu_wb_done_o   (mdu_wb_done_o),
    .mdu_wb_addr_o   (mdu_wb_addr_o)
  );

  always #5 clk = ~clk;

  // Upstream must never request an ALU write while stall is up.
  always @(posedge clk) begin
    if (rst_n && alu_reg_we_i && alu_stall_o) begin
      fails++;
      $error("FAIL protocol: alu_reg_we_i=1 while alu_stall_o=1");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a,
                        input logic [31:0] d);
    chk({tag, "_we"}, 32'(reg_we_o), 32'd1);
    chk({tag, "_addr"}, 32'(reg_waddr_o), 32'(a));
    chk({tag, "_data"}, reg_wdata_o, d);
  endtask

  logic [4:0]  vaddr [10];
  logic [31:0] vdata [10];

  initial begin
    rst_n = 1'b0;
    alu_reg_we_i = 1'b0;
    alu_reg_waddr_i = '0;
    alu_result_i = '0;
    mdu_valid_i = 1'b0;
    mdu_waddr_i = '0;
    mdu_result_i = '0;
    int_assert_i = 1'b0;
    vaddr = '{5'd1, 5'd2, 5'd0, 5'd3, 5'd4,
              5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    for (int i = 0; i < 10; i++) vdata[i] = 32'hA000 + 32'(i);

    // reset
    step();
    step();
    chk("rst_we", 32'(reg_we_o), 0);
    chk("rst_stall", 32'(alu_stall_o), 0);
    chk("rst_done", 32'(mdu_wb_done_o), 0);
    chk("rst_ready", 32'(mdu_ready_o), 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(mdu_ready_o), 1);
    step();
    chk("idle_we", 32'(reg_we_o), 0);

    // ALU only
    alu_reg_we_i = 1'b1;
    alu_reg_waddr_i = 5'd5;
    alu_result_i = 32'hDEADBEEF;
    step();
    chk_wr("alu", 5'd5, 32'hDEADBEEF);
    alu_reg_waddr_i = 5'd0;
    step();
    chk("alu_x0_we", 32'(reg_we_o), 0);
    alu_reg_we_i = 1'b0;
    step();
    chk("alu_idle_we", 32'(reg_we_o), 0);

    // MDU back-to-back with drain: writes from push+2
    mdu_valid_i = 1'b1;
    mdu_waddr_i = 5'd1;
    mdu_result_i = 32'h11;
    step();
    chk("mdu_first_we", 32'(reg_we_o), 0);
    mdu_waddr_i = 5'd2;
    mdu_result_i = 32'h22;
    step();
    chk_wr("mdu1", 5'd1, 32'h11);
    chk("mdu1_done", 32'(mdu_wb_done_o), 1);
    mdu_waddr_i = 5'd3;
    mdu_result_i = 32'h33;
    step();
    chk_wr("mdu2", 5'd2, 32'h22);
    chk("mdu2_done", 32'(mdu_wb_done_o), 1);
    mdu_valid_i = 1'b0;
    step();
    chk_wr("mdu3", 5'd3, 32'h33);
    chk("mdu3_done_addr", 32'(mdu_wb_addr_o), 3);
    step();
    chk("mdu_end_we", 32'(reg_we_o), 0);
    chk("mdu_end_done", 32'(mdu_wb_done_o), 0);

    // fill under interrupt; ALU request also blocked
    int_assert_i = 1'b1;
    alu_reg_we_i = 1'b1;
    alu_reg_waddr_i = 5'd4;
    alu_result_i = 32'h44;
    mdu_valid_i = 1'b1;
    mdu_waddr_i = 5'd8;
    mdu_result_i = 32'h88;
    step();
    chk("int_we0", 32'(reg_we_o), 0);
    chk("int_ready1", 32'(mdu_ready_o), 1);
    mdu_waddr_i = 5'd9;
    mdu_result_i = 32'h99;
    step();
    chk("int_full_ready", 32'(mdu_ready_o), 0);
    chk("int_we1", 32'(reg_we_o), 0);
    mdu_waddr_i = 5'd10;
    mdu_result_i = 32'hAA;
    step();
    chk("int_we2", 32'(reg_we_o), 0);
    chk("int_done2", 32'(mdu_wb_done_o), 0);
    chk("third_waits", 32'(mdu_ready_o), 0);
    int_assert_i = 1'b0;
    alu_reg_we_i = 1'b0;
    step();
    chk_wr("fill8", 5'd8, 32'h88);
    chk("ready_again", 32'(mdu_ready_o), 1);
    step();
    chk_wr("fill9", 5'd9, 32'h99);
    mdu_valid_i = 1'b0;
    step();
    chk_wr("fill10", 5'd10, 32'hAA);
    step();
    chk("fill_end_done", 32'(mdu_wb_done_o), 0);

    // starvation: entry addr 7 vs continuous ALU writes
    mdu_valid_i = 1'b1;
    mdu_waddr_i = 5'd7;
    mdu_result_i = 32'h77;
    alu_reg_we_i = 1'b1;
    alu_reg_waddr_i = 5'd3;
    for (int i = 0; i < 5; i++) begin
      alu_result_i = 32'h1000 + 32'(i);
      step();
      mdu_valid_i = 1'b0;
      chk_wr("starve_alu", 5'd3, 32'h1000 + 32'(i));
      chk("starve_stall", 32'(alu_stall_o), (i == 4) ? 32'd1 : 32'd0);
    end
    alu_reg_we_i = 1'b0;
    step();
    chk_wr("starve_mdu7", 5'd7, 32'h77);
    chk("starve_stall_drop", 32'(alu_stall_o), 0);
    chk("starve_done", 32'(mdu_wb_done_o), 1);
    alu_reg_we_i = 1'b1;
    alu_result_i = 32'h2000;
    step();
    chk_wr("post_starve_alu", 5'd3, 32'h2000);
    alu_reg_we_i = 1'b0;
    step();

    // 10 pushes with drain, x0 entry, pointer wrap
    for (int k = 0; k < 11; k++) begin
      mdu_valid_i = (k < 10);
      mdu_waddr_i = (k < 10) ? vaddr[k] : 5'd0;
      mdu_result_i = (k < 10) ? vdata[k] : 32'd0;
      chk("wrap_ready", 32'(mdu_ready_o), 1);
      step();
      if (k == 0) begin
        chk("wrap_first_done", 32'(mdu_wb_done_o), 0);
      end else begin
        chk("wrap_done", 32'(mdu_wb_done_o), 1);
        chk("wrap_done_addr", 32'(mdu_wb_addr_o), 32'(vaddr[k-1]));
        if (vaddr[k-1] == 5'd0) begin
          chk("wrap_x0_we", 32'(reg_we_o), 0);
        end else begin
          chk_wr("wrap", vaddr[k-1], vdata[k-1]);
        end
      end
    end
    mdu_valid_i = 1'b0;
    step();

    // reset with FIFO full
    int_assert_i = 1'b1;
    mdu_valid_i = 1'b1;
    mdu_waddr_i = 5'd12;
    mdu_result_i = 32'hC0;
    step();
    step();
    chk("pre_rst_full", 32'(mdu_ready_o), 0);
    rst_n = 1'b0;
    int_assert_i = 1'b0;
    mdu_valid_i = 1'b0;
    step();
    chk("mrst_we", 32'(reg_we_o), 0);
    chk("mrst_waddr", 32'(reg_waddr_o), 0);
    chk("mrst_wdata", reg_wdata_o, 0);
    chk("mrst_done", 32'(mdu_wb_done_o), 0);
    chk("mrst_done_addr", 32'(mdu_wb_addr_o), 0);
    chk("mrst_stall", 32'(alu_stall_o), 0);
    chk("mrst_ready", 32'(mdu_ready_o), 0);
    rst_n = 1'b1;
    #1;
    chk("mrst_ready_hi", 32'(mdu_ready_o), 1);
    step();
    chk("no_stale_we", 32'(reg_we_o), 0);
    chk("no_stale_done", 32'(mdu_wb_done_o), 0);
    step();
    chk("no_stale_we2", 32'(reg_we_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
